lane_dispatcher: RTL and testbench
==================================

# lane_dispatcher

Upstream feeder for the 64-bit four-output demultiplexer. Accepts tagged 64-bit words over a valid/ready handshake, buffers them in a small FIFO, and presents one word at a time on `X`/`B` to the demux. Each word is held stable until the destination lane acknowledges it. While no word is in flight, it drives `X = 0` so all demux outputs read zero.

## Interface
- `DATA_W`, default 64: word width; matches demux `X`.
- `SEL_W`, default 2: lane-select width; matches demux `B`; lanes = 2**SEL_W.
- `DEPTH`, default 4: FIFO entries; power of two, ≥2.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  DATA_W  word to dispatch.
- `in_sel`  in  SEL_W  destination lane of `in_data`.
- `in_valid`  in  1  `in_data`/`in_sel` valid.
- `in_ready`  out  1  FIFO can accept; transfer when `in_valid & in_ready` at an edge.
- `X`  out  DATA_W  data to demux.
- `B`  out  SEL_W  lane select to demux.
- `out_valid`  out  1  `X`/`B` carry a word in flight.
- `lane_ack`  in  2**SEL_W  per-lane consume strobe, one bit per demux output.
- `level`  out  clog2(DEPTH+1)  FIFO occupancy, excluding the word in flight.

## Operation
- Reset values: `X = 0`, `B = 0`, `out_valid = 0`, `level = 0`, `in_ready = 1`, FIFO pointers = 0, FSM = IDLE.
- FIFO: registered circular buffer.
  - Read/write pointers are log2(DEPTH) bits and wrap naturally at DEPTH−1→0.
  - `level` is a registered count.
  - `in_ready = (level != DEPTH)`; it is combinational from `level` only, never from `lane_ack`.
- FSM states:
  - IDLE: `out_valid = 0`, `X = 0`, `B = 0`. If `level > 0`, pop the head into `X`/`B`, set `out_valid`, go to SEND.
  - SEND: hold `X`/`B` stable. When `lane_ack[B] = 1` at an edge, the word is consumed:
    - if `level > 0` at that edge, pop the next word into `X`/`B` and stay in SEND (back-to-back, no bubble);
    - otherwise clear `X`/`B` to 0, deassert `out_valid`, go to IDLE.
- `lane_ack` bits for lanes other than `B` are ignored. In IDLE, all of `lane_ack` is ignored.
- Simultaneous push and pop in one edge: `level` is unchanged and both pointers advance. A pop and a push on a full FIFO cannot occur in the same cycle, because `in_ready = 0` when full.
- A push into an empty FIFO while IDLE is not bypassed. The word goes through the FIFO.
- An asserted `rst` mid-transfer discards the FIFO contents and the in-flight word immediately, regardless of the clock.

## Timing
- Input→output latency: a handshake at edge N gives `out_valid = 1` with that word after edge N+1 (FSM idle, FIFO previously empty).
- Sustained throughput: one word per cycle when `lane_ack[B]` is held high and the FIFO is non-empty.
- `X`/`B` change only at an edge where the word is consumed, or on an IDLE→SEND pop.
- `in_ready` falls in the cycle after the push that fills the FIFO. It rises in the cycle after the first pop from full.

## Configuration
- `LANE_DISPATCH_RR_EN` defined:
  - `in_sel` is ignored.
  - Lanes are assigned round-robin 0,1,2,3,0,… at push time, from a SEL_W-bit counter that resets to 0 and wraps.
  - The assigned lane is stored in the FIFO alongside the data.
- Not defined: each word's lane is the `in_sel` value captured at push time. No counter is instantiated.

## Structure
- Shared package `lane_dispatch_pkg`:
  - `LANES` constant;
  - `lane_sel_t` typedef (SEL_W bits);
  - FSM state enum `{IDLE, SEND}`;
  - default `DATA_W`/`DEPTH` constants.
- One sub-module: `dispatch_fifo` (storage, pointers, `level`, push/pop). The top level holds the FSM, the output registers and the optional round-robin counter.

## Test plan
- Reset then idle: hold `rst` high for 2 cycles, then release → `X = 0`, `B = 0`, `out_valid = 0`, `in_ready = 1`, `level = 0`; pulse `lane_ack = 4'b1111` → no change.
- Single word: push `in_data = 1`, `in_sel = 2'b10`; `lane_ack = 0` for 5 cycles, then `lane_ack = 4'b0100` → `X = 1`, `B = 2'b10`, `out_valid` held for 5 cycles, then `out_valid = 0` and `X = 0` on the next edge.
- Wrong-lane ack: with word 8 in flight on lane 3, pulse `lane_ack = 4'b0111` → word still held; then `lane_ack = 4'b1000` → consumed.
- Fill and wrap:
  - with `lane_ack = 0`, push 5 words (values 1, 2, 4, 8, 16) → first in flight, `level = 4`, `in_ready = 0`;
  - then hold `lane_ack = 4'b1111`, push 3 more words (32, 64, 128) → all 8 words emerge in order on consecutive cycles, pointers wrap with no loss or duplication.
- Simultaneous push/pop: at `level = 2`, push while consuming in the same cycle → `level` stays 2, order preserved.
- Reset mid-operation: assert `rst` asynchronously with 3 queued words and 1 in flight → outputs return to reset values before the next edge; no queued word appears after release. With `LANE_DISPATCH_RR_EN` defined, the next 4 pushes are assigned lanes 0, 1, 2, 3.

Source files
------------

// File: rtl/lane_dispatch_pkg.sv
// Shared definitions for the lane dispatcher slice.
//   DEF_DATA_W / DEF_SEL_W / DEF_DEPTH : default word width, lane-select width, FIFO depth
//   LANES                              : number of demux lanes for the default select width
//   lane_sel_t                         : lane-select type for the default select width
//   disp_state_t                       : dispatcher FSM states
package lane_dispatch_pkg;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_SEL_W  = 2;
  localparam int DEF_DEPTH  = 4;
  localparam int LANES      = 1 << DEF_SEL_W;

  typedef logic [DEF_SEL_W-1:0] lane_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } disp_state_t;

endpackage

// File: rtl/lane_dispatch_fifo.sv
// dispatch_fifo: registered circular buffer holding {data, lane} pairs.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (pointers and level only)
//   push, wr_data,
//   wr_sel            : write strobe and the word/lane written at the tail
//   pop               : advance the head; rd_data/rd_sel show the head entry
//   level             : registered occupancy
//   full              : level == DEPTH
module dispatch_fifo
  import lane_dispatch_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int SEL_W  = DEF_SEL_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic [SEL_W-1:0]  rd_sel,
  output logic [LVL_W-1:0]  level,
  output logic              full
);

  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [SEL_W-1:0]  sel_mem  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= wr_data;
      sel_mem[wr_ptr]  <= wr_sel;
    end
  end

  // Pointers are PTR_W bits wide so DEPTH-1 -> 0 wraps for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  assign rd_data = data_mem[rd_ptr];
  assign rd_sel  = sel_mem[rd_ptr];
  assign full    = (level == LVL_W'(DEPTH));

endmodule

// File: rtl/lane_dispatcher.sv
// lane_dispatcher: buffers tagged words and presents one at a time to the
// 64-bit four-output demux, holding X/B until the addressed lane acknowledges.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_data, in_sel,
//   in_valid, in_ready  : upstream valid/ready word + destination lane
//   X, B, out_valid     : word and lane select to the demux; X=0 while idle
//   lane_ack            : per-lane consume strobe; only lane_ack[B] matters in SEND
//   level               : FIFO occupancy, excluding the word in flight
// Build option:
//   LANE_DISPATCH_RR_EN : ignore in_sel, assign lanes round-robin at push time
module lane_dispatcher
  import lane_dispatch_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int SEL_W  = DEF_SEL_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int LANE_N = 1 << SEL_W,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] X,
  output logic [SEL_W-1:0]  B,
  output logic              out_valid,
  input  logic [LANE_N-1:0] lane_ack,
  output logic [LVL_W-1:0]  level
);

  disp_state_t       state_q, state_d;
  logic [DATA_W-1:0] x_p0, x_d;
  logic [SEL_W-1:0]  b_p0, b_d;
  logic              vld_p0, vld_d;

  logic              push, pop, full, ack_hit, have_word;
  logic [DATA_W-1:0] rd_data;
  logic [SEL_W-1:0]  rd_sel;
  logic [SEL_W-1:0]  wr_sel;

  assign in_ready  = ~full;
  assign push      = in_valid & in_ready;
  assign have_word = (level != '0);
  assign ack_hit   = lane_ack[b_p0];

`ifdef LANE_DISPATCH_RR_EN
  logic [SEL_W-1:0] rr_q;
  logic             unused_in_sel;

  assign unused_in_sel = ^in_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= rr_q + SEL_W'(1);
    end
  end

  assign wr_sel = rr_q;
`else
  assign wr_sel = in_sel;
`endif

  dispatch_fifo #(
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .wr_sel  (wr_sel),
    .pop     (pop),
    .rd_data (rd_data),
    .rd_sel  (rd_sel),
    .level   (level),
    .full    (full)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    x_d     = x_p0;
    b_d     = b_p0;
    vld_d   = vld_p0;
    case (state_q)
      IDLE: begin
        if (have_word) begin
          pop     = 1'b1;
          x_d     = rd_data;
          b_d     = rd_sel;
          vld_d   = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        // Consume-and-reload in one edge keeps back-to-back words bubble-free.
        if (ack_hit) begin
          if (have_word) begin
            pop = 1'b1;
            x_d = rd_data;
            b_d = rd_sel;
          end else begin
            x_d     = '0;
            b_d     = '0;
            vld_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: X/B are cleared on reset so the demux reads all zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_p0    <= '0;
      b_p0    <= '0;
      vld_p0  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_p0    <= x_d;
      b_p0    <= b_d;
      vld_p0  <= vld_d;
    end
  end

  assign X         = x_p0;
  assign B         = b_p0;
  assign out_valid = vld_p0;

endmodule

// File: tb/tb_lane_dispatcher.sv
module tb_lane_dispatcher;

  localparam int DATA_W = 64;
  localparam int SEL_W  = 2;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_sel;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] X;
  logic [SEL_W-1:0]  B;
  logic              out_valid;
  logic [3:0]        lane_ack;
  logic [LVL_W-1:0]  level;

  lane_dispatcher #(.DATA_W(DATA_W), .SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .B         (B),
    .out_valid (out_valid),
    .lane_ack  (lane_ack),
    .level     (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [SEL_W-1:0]  s;
  } word_t;

  // Reference model: a queue of accepted words plus the one word in flight.
  word_t            m_fifo[$];
  word_t            exp_q[$];
  word_t            m_cur;
  word_t            sb_e;
  bit               m_busy;
  bit               m_acc;
  logic [SEL_W-1:0] m_rr;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_fifo.delete();
      exp_q.delete();
      m_busy = 1'b0;
      m_cur  = '0;
      m_rr   = '0;
      m_acc  = 1'b0;
    end else begin
      word_t w;
      bit    consumed;
      m_acc    = in_valid && (m_fifo.size() < DEPTH);
      consumed = m_busy && lane_ack[m_cur.s];
      if (!m_busy || consumed) begin
        if (m_fifo.size() > 0) begin
          m_cur  = m_fifo.pop_front();
          m_busy = 1'b1;
        end else begin
          m_cur  = '0;
          m_busy = 1'b0;
        end
      end
      if (m_acc) begin
        w.d = in_data;
`ifdef LANE_DISPATCH_RR_EN
        w.s  = m_rr;
        m_rr = m_rr + 2'd1;
`else
        w.s = in_sel;
`endif
        m_fifo.push_back(w);
        exp_q.push_back(w);
      end
    end
  end

  // Monitor: cycle-level state checks plus an order scoreboard on every consume.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_X", X, 64'd0);
      chk("rst_B", {62'd0, B}, 64'd0);
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_level", {61'd0, level}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    end else begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_busy});
      chk("X", X, m_busy ? m_cur.d : 64'd0);
      chk("B", {62'd0, B}, m_busy ? {62'd0, m_cur.s} : 64'd0);
      chk("level", {61'd0, level}, 64'(m_fifo.size()));
      chk("in_ready", {63'd0, in_ready}, {63'd0, (m_fifo.size() != DEPTH)});
      if (out_valid && lane_ack[B]) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_empty: got word %0h lane %0d expected none", X, B);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_data", X, sb_e.d);
          chk("sb_lane", {62'd0, B}, {62'd0, sb_e.s});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] s);
    in_data  = d;
    in_sel   = s;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (m_acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    n_tests++;
    n_fail++;
    $display("FAIL push_timeout: got no accept for %0h expected accept within 50 cycles", d);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_data  = '0;
    in_sel   = '0;
    in_valid = 1'b0;
    lane_ack = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Reset then idle: acks ignored while IDLE
    lane_ack = 4'b1111;
    step();
    lane_ack = 4'b0000;
    step();

    // Single word held for 5 cycles, then consumed
    push(64'd1, 2'b10);
    repeat (5) step();
    lane_ack = 4'b0100;
    step();
    lane_ack = 4'b0000;
    repeat (2) step();

    // Wrong-lane ack ignored, right lane consumes
    push(64'd8, 2'b11);
    step();
    lane_ack = 4'b0111;
    step();
    lane_ack = 4'b0000;
    step();
    lane_ack = 4'b1000;
    step();
    lane_ack = 4'b1111;
    repeat (3) step();
    lane_ack = 4'b0000;
    step();

    // Fill to full, then stream through a pointer wrap
    for (int i = 0; i < 5; i++) push(64'd1 << i, 2'(i));
    lane_ack = 4'b1111;
    for (int i = 5; i < 8; i++) push(64'd1 << i, 2'(i));
    repeat (8) step();
    lane_ack = 4'b0000;
    step();

    // Simultaneous push and pop at level 2
    for (int i = 0; i < 3; i++) push(64'h100 + 64'(i), 2'(i + 1));
    lane_ack = 4'b1111;
    push(64'h103, 2'd0);
    lane_ack = 4'b0000;
    step();
    lane_ack = 4'b1111;
    repeat (5) step();
    lane_ack = 4'b0000;
    step();

    // Asynchronous reset with 3 queued and 1 in flight
    for (int i = 0; i < 4; i++) push(64'h200 + 64'(i), 2'(i));
    #1 rst = 1'b1;
    repeat (2) step();
    rst      = 1'b0;
    lane_ack = 4'b1111;
    repeat (3) step();
    for (int i = 0; i < 4; i++) push(64'h300 + 64'(i), 2'($urandom_range(0, 3)));
    repeat (6) step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = {$urandom, $urandom};
      in_sel   = 2'($urandom_range(0, 3));
      lane_ack = 4'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0;
    lane_ack = 4'b1111;
    repeat (12) step();

    chk("drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
